// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: boot delay, imem req/ready handshake, decode-stall hold,
// deferred branch redirect and sticky instruction-memory timeout.
//
// state | meaning
// BOOT  | post-reset delay, PC forced to RESET_VECTOR, no requests
// REQ   | first cycle of a request for pcf
// WAIT  | request outstanding, waiting for imem_ready
// HOLD  | instruction ready but decode stalled; pcf held, no request
// ERR   | imem timeout; left only through rst
module fetch_ctrl #(
    parameter int                 A_WIDTH      = 32,
    parameter logic [A_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                 BOOT_CYCLES  = 4,
    parameter int                 MAX_WAIT     = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pc_src_e,
    input  logic [A_WIDTH-1:0] pc_target_e,
    input  logic [A_WIDTH-1:0] pc_4f,
    input  logic               stall_d,
    input  logic               imem_ready,
    output logic               imem_req,
    output logic               pc_en,
    output logic [A_WIDTH-1:0] pc_next,
    output logic               fd_en,
    output logic               fd_clr,
    output logic               instr_valid_f,
    output logic               redirect_pending,
    output logic               fetch_err
);

    localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_MAX  = WW'(MAX_WAIT);

    typedef enum logic [2:0] {
        S_BOOT = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t             state, state_n;
    logic [BW-1:0]      bcnt, bcnt_n;
    logic [WW-1:0]      wcnt, wcnt_n;
    logic [A_WIDTH-1:0] tgt, tgt_n;
    logic               pend, pend_n;
    logic               err, err_n;
    logic               resp;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_BOOT;
            bcnt  <= '0;
            wcnt  <= '0;
            tgt   <= RESET_VECTOR;
            pend  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            bcnt  <= bcnt_n;
            wcnt  <= wcnt_n;
            tgt   <= tgt_n;
            pend  <= pend_n;
            err   <= err_n;
        end
    end

    assign resp = imem_ready && ((state == S_REQ) || (state == S_WAIT));

    always_comb begin
        state_n  = state;
        bcnt_n   = bcnt;
        wcnt_n   = wcnt;
        tgt_n    = tgt;
        pend_n   = pend;
        err_n    = err;
        imem_req = 1'b0;
        pc_en    = 1'b0;
        pc_next  = pc_4f;
        fd_en    = 1'b0;
        fd_clr   = 1'b0;

        if (rst) begin
            // outputs already show the boot values during the reset cycle itself
            state_n = S_BOOT;
            bcnt_n  = '0;
            wcnt_n  = '0;
            pend_n  = 1'b0;
            err_n   = 1'b0;
            pc_en   = 1'b1;
            pc_next = RESET_VECTOR;
            fd_en   = 1'b1;
            fd_clr  = 1'b1;
        end else begin
            case (state)
                S_BOOT: begin
                    pc_en   = 1'b1;
                    pc_next = RESET_VECTOR;
                    fd_en   = 1'b1;
                    fd_clr  = 1'b1;
                    if (bcnt == BOOT_LAST) begin
                        state_n = S_REQ;
                        bcnt_n  = '0;
                    end else begin
                        bcnt_n = bcnt + BW'(1);
                    end
                end
                S_REQ, S_WAIT, S_HOLD: begin
                    imem_req = (state != S_HOLD);
                    wcnt_n   = '0;
                    if (pc_src_e) begin
                        fd_en  = 1'b1;
                        fd_clr = 1'b1;
                        if (resp || (state == S_HOLD)) begin
                            pc_en   = 1'b1;
                            pc_next = pc_target_e;
                            pend_n  = 1'b0;
                            state_n = S_REQ;
                        end else begin
                            tgt_n   = pc_target_e;
                            pend_n  = 1'b1;
                            state_n = S_WAIT;
                        end
                    end else if (resp && pend) begin
                        // response belongs to the wrong-path pcf; drop it
                        fd_en   = 1'b1;
                        fd_clr  = 1'b1;
                        pc_en   = 1'b1;
                        pc_next = tgt;
                        pend_n  = 1'b0;
                        state_n = S_REQ;
                    end else if (resp || (state == S_HOLD)) begin
                        if (!stall_d) begin
                            fd_en   = 1'b1;
                            pc_en   = 1'b1;
                            pc_next = pc_4f;
                            state_n = S_REQ;
                        end else begin
                            state_n = S_HOLD;
                        end
                    end else begin
                        fd_en  = !stall_d;
                        fd_clr = !stall_d;
                        if (wcnt == WAIT_MAX) begin
                            err_n   = 1'b1;
                            state_n = S_ERR;
                        end else begin
                            wcnt_n  = wcnt + WW'(1);
                            state_n = S_WAIT;
                        end
                    end
                end
                S_ERR: begin
                    fd_en  = 1'b1;
                    fd_clr = 1'b1;
                    err_n  = 1'b1;
                end
                default: state_n = S_BOOT;
            endcase
        end
    end

    assign instr_valid_f    = fd_en && !fd_clr;
    assign redirect_pending = pend && !rst;
    assign fetch_err        = err && !rst;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: boot, streaming, wait states, stall, redirect, timeout.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_src_e;
    logic [31:0] pc_target_e;
    logic [31:0] pc_4f;
    logic        stall_d;
    logic        imem_ready;
    logic        imem_req;
    logic        pc_en;
    logic [31:0] pc_next;
    logic        fd_en;
    logic        fd_clr;
    logic        instr_valid_f;
    logic        redirect_pending;
    logic        fetch_err;
    logic [31:0] pcf = 32'hDEAD_BEEF;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // PC register and incrementer around the controller
    always_ff @(posedge clk) if (pc_en) pcf <= pc_next;
    assign pc_4f = pcf + 32'd4;

    fetch_ctrl #(
        .A_WIDTH(32), .RESET_VECTOR(32'h0), .BOOT_CYCLES(4), .MAX_WAIT(15)
    ) dut (
        .clk(clk), .rst(rst), .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
        .pc_4f(pc_4f), .stall_d(stall_d), .imem_ready(imem_ready),
        .imem_req(imem_req), .pc_en(pc_en), .pc_next(pc_next), .fd_en(fd_en),
        .fd_clr(fd_clr), .instr_valid_f(instr_valid_f),
        .redirect_pending(redirect_pending), .fetch_err(fetch_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; pc_src_e = 1'b0; pc_target_e = 32'h0;
        stall_d = 1'b0; imem_ready = 1'b0;

        // reset cycles
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("rst_pc_en", pc_en, 1);
            chk("rst_pc_next", pc_next, 0);
            chk("rst_imem_req", imem_req, 0);
            chk("rst_fd_clr", fd_clr, 1);
            chk("rst_fetch_err", fetch_err, 0);
            tick();
        end
        rst = 1'b0;

        // 1. boot delay
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("boot_imem_req", imem_req, 0);
            chk("boot_pc_en", pc_en, 1);
            chk("boot_pc_next", pc_next, 0);
            chk("boot_fetch_err", fetch_err, 0);
            tick();
        end

        // 2. zero-wait stream
        imem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("stream_imem_req", imem_req, 1);
            chk("stream_pcf", pcf, 32'(i * 4));
            chk("stream_valid", instr_valid_f, 1);
            chk("stream_fd_clr", fd_clr, 0);
            chk("stream_pc_next", pc_next, 32'(i * 4 + 4));
            tick();
        end

        // 3. two wait states, ready on the third request cycle
        imem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("wait_imem_req", imem_req, 1);
            chk("wait_pc_en", pc_en, 0);
            chk("wait_fd_en", fd_en, 1);
            chk("wait_fd_clr", fd_clr, 1);
            tick();
        end
        imem_ready = 1'b1;
        #1;
        chk("wait_resp_req", imem_req, 1);
        chk("wait_resp_pc_en", pc_en, 1);
        chk("wait_resp_valid", instr_valid_f, 1);
        chk("wait_resp_pc_next", pc_next, 32'h14);
        tick();

        // 4a. stall on response, then release
        chk("stall_pcf", pcf, 32'h14);
        stall_d = 1'b1;
        #1;
        chk("stall_req_pc_en", pc_en, 0);
        chk("stall_req_fd_en", fd_en, 0);
        tick();
        imem_ready = 1'b0;
        #1;
        chk("hold_imem_req", imem_req, 0);
        chk("hold_pc_en", pc_en, 0);
        chk("hold_fd_en", fd_en, 0);
        tick();
        stall_d = 1'b0;
        #1;
        chk("hold_rel_fd_en", fd_en, 1);
        chk("hold_rel_valid", instr_valid_f, 1);
        chk("hold_rel_pc_en", pc_en, 1);
        chk("hold_rel_pc_next", pc_next, 32'h18);
        tick();

        // 4b. stall, then branch while held
        chk("stall2_pcf", pcf, 32'h18);
        imem_ready = 1'b1; stall_d = 1'b1;
        #1;
        chk("stall2_fd_en", fd_en, 0);
        tick();
        imem_ready = 1'b0; pc_src_e = 1'b1; pc_target_e = 32'h40;
        #1;
        chk("hold_br_fd_clr", fd_clr, 1);
        chk("hold_br_valid", instr_valid_f, 0);
        chk("hold_br_pc_en", pc_en, 1);
        chk("hold_br_pc_next", pc_next, 32'h40);
        tick();
        pc_src_e = 1'b0; stall_d = 1'b0;

        // 5. redirect while a fetch is outstanding
        chk("redir_pcf", pcf, 32'h40);
        #1;
        chk("redir_req_bubble", fd_clr, 1);
        tick();
        pc_src_e = 1'b1; pc_target_e = 32'h100;
        #1;
        chk("redir_latch_pc_en", pc_en, 0);
        chk("redir_latch_fd_clr", fd_clr, 1);
        chk("redir_latch_pend", redirect_pending, 0);
        tick();
        pc_src_e = 1'b0; pc_target_e = 32'h200;
        #1;
        chk("redir_pend", redirect_pending, 1);
        chk("redir_pend_req", imem_req, 1);
        chk("redir_pend_pc_en", pc_en, 0);
        tick();
        imem_ready = 1'b1;
        #1;
        chk("redir_resp_pend", redirect_pending, 1);
        chk("redir_resp_fd_clr", fd_clr, 1);
        chk("redir_resp_valid", instr_valid_f, 0);
        chk("redir_resp_pc_en", pc_en, 1);
        chk("redir_resp_pc_next", pc_next, 32'h100);
        tick();

        // 6. timeout after 16 request cycles
        imem_ready = 1'b0;
        chk("tmo_pcf", pcf, 32'h100);
        chk("tmo_pend_clr", redirect_pending, 0);
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("tmo_imem_req", imem_req, 1);
            chk("tmo_fetch_err", fetch_err, 0);
            tick();
        end
        #1;
        chk("err_fetch_err", fetch_err, 1);
        chk("err_imem_req", imem_req, 0);
        chk("err_pc_en", pc_en, 0);
        chk("err_fd_clr", fd_clr, 1);
        tick();
        imem_ready = 1'b1;
        #1;
        chk("err_sticky", fetch_err, 1);
        chk("err_ready_pc_en", pc_en, 0);
        chk("err_ready_req", imem_req, 0);
        tick();
        rst = 1'b1; imem_ready = 1'b0;
        #1;
        chk("err_rst_fetch_err", fetch_err, 0);
        chk("err_rst_pc_en", pc_en, 1);
        tick();
        rst = 1'b0;
        #1;
        chk("reboot_fetch_err", fetch_err, 0);
        chk("reboot_imem_req", imem_req, 0);
        chk("reboot_pc_next", pc_next, 0);
        tick();
        chk("reboot_pcf", pcf, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
